// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, receiver states, parity helper.
// The 32-bit transmitter uses the same package, so both ends agree on framing.
package uart_pkg;

    localparam int UART_DATA_BITS  = 32;
    localparam int UART_FRAME_BITS = 34;  // data + parity + stop, after the start bit

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_e;

    // Parity bit a transmitter appends so that data plus parity has the selected parity.
    function automatic logic parity_bit(input logic [UART_DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input synchronizer: STAGES-deep flop chain that resets to 1.
// A reset value of 1 keeps the receiver from seeing a false start bit on reset.
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: start, 32 data bits LSB first, parity, stop; one bit per baud clock.
// Delivers words through a valid/ack holding register with overrun and framing checks.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit PARITY_ODD  = 1'b0
) (
    input  logic        CLK_Baudin,
    input  logic        RstRx,
    input  logic        SerialDataIn,
    input  logic        RxAck,
    output logic [31:0] DataOut,
    output logic        RxValid,
    output logic        DoneRx,
    output logic        ParityErr,
    output logic        FrameErr,
    output logic        Overrun,
    output logic        receiving
);

    logic rx_s;

    uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_i (CLK_Baudin),
        .rst_i (RstRx),
        .d_i   (SerialDataIn),
        .q_o   (rx_s)
    );

    uart_state_e                state_q, state_d;
    logic [4:0]                 idx_q, idx_d;
    logic                       acc_q, acc_d;
    logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
    logic [UART_DATA_BITS-1:0]  data_q, data_d;
    logic                       valid_q, valid_d;
    logic                       done_q, done_d;
    logic                       perr_q, perr_d;
    logic                       ferr_q, ferr_d;
    logic                       ovr_q, ovr_d;
    logic                       rcv_q, rcv_d;

    always_ff @(posedge CLK_Baudin or posedge RstRx) begin
        if (RstRx) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= 1'b0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            rcv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            rcv_q   <= rcv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ovr_d   = ovr_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;

        if (RxAck && valid_q) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = DATA;
                    idx_d   = '0;
                    acc_d   = 1'b0;
                end
            end
            DATA: begin
                shift_d[idx_q] = rx_s;
                acc_d          = acc_q ^ rx_s;
                idx_d          = idx_q + 5'd1;
                if (idx_q == 5'(UART_DATA_BITS - 1)) begin
                    state_d = PARITY;
                end
            end
            PARITY: begin
                acc_d   = acc_q ^ rx_s;
                state_d = STOP;
            end
            STOP: begin
                done_d = 1'b1;
                if (rx_s) begin
                    state_d = IDLE;
                    if (!valid_q || RxAck) begin
                        data_d  = shift_q;
                        perr_d  = (acc_q != PARITY_ODD);
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    // Bad stop bit: the holding register is left exactly as it was, ack included.
                    state_d = BREAK;
                    ferr_d  = 1'b1;
                    valid_d = valid_q;
                    ovr_d   = ovr_q;
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        rcv_d = (state_d == DATA) || (state_d == PARITY) || (state_d == STOP);
    end

    assign DataOut   = data_q;
    assign RxValid   = valid_q;
    assign DoneRx    = done_q;
    assign ParityErr = perr_q;
    assign FrameErr  = ferr_q;
    assign Overrun   = ovr_q;
    assign receiving = rcv_q;

endmodule
